// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
//   Chunk-serial two's-complement adder/subtractor. One CHUNK-bit adder
//   slice is reused N = WIDTH/CHUNK times, LSB chunk first, so a full
//   WIDTH-bit add or subtract takes N RUN cycles plus one DONE cycle.
//   Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
//
// Optional feature (compile-time macro):
//   ADDSUB_SAT_EN - when defined, a signed overflow on the last chunk
//                   replaces sum with the saturated extreme that matches
//                   the sign of the true result. Undefined: sum wraps.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, honoured only in IDLE or DONE
//   sub    in   1      0 = a+b, 1 = a-b (captured with start)
//   a, b   in   WIDTH  operands (captured with start)
//   busy   out  1      high while chunks are being processed
//   done   out  1      one-cycle pulse, sum/ovfl/cout valid
//   sum    out  WIDTH  result, held until the next accepted start
//   ovfl   out  1      signed overflow of the whole operation
//   cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
// ---------------------------------------------------------------------------
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             cout
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
            $error("addsub_serial: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovfl_q, ovfl_d;
    logic             cout_q, cout_d;

    // Operand chunks, selected by the chunk counter.
    logic [CHUNK-1:0] a_chunk [N];
    logic [CHUNK-1:0] b_chunk [N];
    logic [CHUNK-1:0] a_sel, b_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chunk
            assign a_chunk[gi] = opa_q[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = opb_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sel = a_chunk[i];
                b_sel = b_chunk[i];
            end
        end
    end

    // The single shared adder slice.
    logic [CHUNK:0]   slice_w;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic             msb_cin;

    assign slice_w = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_q};
    assign slice_s = slice_w[CHUNK-1:0];
    assign slice_c = slice_w[CHUNK];
    // Carry into the top bit of the slice, recovered from its sum bit.
    assign msb_cin = a_sel[CHUNK-1] ^ b_sel[CHUNK-1] ^ slice_s[CHUNK-1];

    // sum with the current chunk replaced by the slice output.
    logic [WIDTH-1:0] sum_run;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sum
            assign sum_run[gi*CHUNK +: CHUNK] =
                (cnt_q == CW'(gi)) ? slice_s : sum_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic last_chunk;
    assign last_chunk = (cnt_q == CW'(N - 1));

`ifdef ADDSUB_SAT_EN
    // On overflow both effective operands share opA's sign, so opA's MSB
    // gives the sign of the true result.
    logic [WIDTH-1:0] sat_val;
    assign sat_val = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    ovfl_d  = 1'b0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = sum_run;
                carry_d = slice_c;
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    state_d = S_DONE;
                    ovfl_d  = msb_cin ^ slice_c;
                    cout_d  = slice_c;
                    // Operands are dropped so nothing outlives the operation
                    // except the held result.
                    cnt_d   = '0;
                    opa_d   = '0;
                    opb_d   = '0;
                    carry_d = 1'b0;
`ifdef ADDSUB_SAT_EN
                    if (msb_cin ^ slice_c) begin
                        sum_d = sat_val;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovfl_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            ovfl_q  <= ovfl_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign ovfl = ovfl_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial
//   Three instances (16/4, 8/8, 32/4) share clock and reset. Each accepted
//   operation pushes its expected {ovfl, cout, sum} from a signed/unsigned
//   integer model; a single compare process pops and checks on every done.
//   Directed cases run on the 16-bit instance, random cases on all three.
// ---------------------------------------------------------------------------
module tb_addsub_serial;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 0, sub16 = 0, busy16, done16, ovfl16, cout16;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    logic        start8 = 0, sub8 = 0, busy8, done8, ovfl8, cout8;
    logic [7:0]  a8 = 0, b8 = 0, sum8;
    logic        start32 = 0, sub32 = 0, busy32, done32, ovfl32, cout32;
    logic [31:0] a32 = 0, b32 = 0, sum32;

    addsub_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .ovfl(ovfl16), .cout(cout16));
    addsub_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .ovfl(ovfl8), .cout(cout8));
    addsub_serial #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .sum(sum32), .ovfl(ovfl32), .cout(cout32));

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] q16[$];
    logic [33:0] q8[$];
    logic [33:0] q32[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: true signed result decides overflow and saturation,
    // unsigned comparison/sum decides carry out. Packed {ovfl, cout, sum}.
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic sv, input int w);
        longint unsigned m, ua, ub, r;
        longint sa, sb, tr, maxv, minv;
        logic ov, co;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, av} & m;
        ub = {32'd0, bv} & m;
        sa = (((ua >> (w - 1)) & 64'd1) != 0) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = (((ub >> (w - 1)) & 64'd1) != 0) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        tr = sv ? (sa - sb) : (sa + sb);
        maxv = longint'(64'd1 << (w - 1)) - 1;
        minv = -longint'(64'd1 << (w - 1));
        ov = (tr > maxv) || (tr < minv);
        co = sv ? (ua >= ub) : ((((ua + ub) >> w) & 64'd1) != 0);
        r  = longint'(tr) & m;
        if (SAT && ov) r = (tr > 0) ? longint'(maxv) : (longint'(minv) & m);
        return {ov, co, r[31:0]};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return m;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    // The single compare process.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n) begin
            if (busy16 && done16) chk("busy_done16", 1, 0);
            if (done16) begin
                if (q16.size() == 0) chk("unexpected_done16", 1, 0);
                else begin
                    e = q16.pop_front();
                    chk("sum16", {48'd0, sum16}, {32'd0, e[31:0]});
                    chk("ovfl16", {63'd0, ovfl16}, {63'd0, e[33]});
                    chk("cout16", {63'd0, cout16}, {63'd0, e[32]});
                end
            end
            if (done8) begin
                if (q8.size() == 0) chk("unexpected_done8", 1, 0);
                else begin
                    e = q8.pop_front();
                    chk("sum8", {56'd0, sum8}, {32'd0, e[31:0]});
                    chk("ovfl8", {63'd0, ovfl8}, {63'd0, e[33]});
                    chk("cout8", {63'd0, cout8}, {63'd0, e[32]});
                end
            end
            if (done32) begin
                if (q32.size() == 0) chk("unexpected_done32", 1, 0);
                else begin
                    e = q32.pop_front();
                    chk("sum32", {32'd0, sum32}, {32'd0, e[31:0]});
                    chk("ovfl32", {63'd0, ovfl32}, {63'd0, e[33]});
                    chk("cout32", {63'd0, cout32}, {63'd0, e[32]});
                end
            end
        end
    end

    // Pins the model against hand-computed values.
    task automatic pin(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic [15:0] es, input logic eo, input logic ec);
        logic [33:0] e;
        e = model({16'd0, av}, {16'd0, bv}, sv, 16);
        chk("model_sum", {32'd0, e[31:0]}, {48'd0, es});
        chk("model_ovfl", {63'd0, e[33]}, {63'd0, eo});
        chk("model_cout", {63'd0, e[32]}, {63'd0, ec});
    endtask

    // Called #1 after an edge; returns after the edge on which start was taken.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        a16 = av; b16 = bv; sub16 = sv; start16 = 1'b1;
        q16.push_back(model({16'd0, av}, {16'd0, bv}, sv, 16));
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    // Counts edges until done, checking busy meanwhile.
    task automatic wait16(output int lat);
        lat = 0;
        while (done16 !== 1'b1 && lat < 20) begin
            chk("busy16_run", {63'd0, busy16}, 64'd1);
            @(posedge clk); #1;
            lat++;
        end
        chk("busy16_at_done", {63'd0, busy16}, 64'd0);
    endtask

    task automatic idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cyc;
        logic [31:0] ra, rb;
        logic        rs;

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy16}, 0);
        chk("rst_done", {63'd0, done16}, 0);
        chk("rst_sum", {48'd0, sum16}, 0);
        chk("rst_ovfl", {63'd0, ovfl16}, 0);
        chk("rst_cout", {63'd0, cout16}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();

        // Test 1: positive overflow, latency N.
        pin(16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0);
        wait16(lat);
        chk("lat_t1", lat, 4);
        idle();

        // Test 2: subtracts, held result in IDLE, corner cases.
        pin(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16(16'h0003, 16'h0005, 1'b1);
        wait16(lat);
        @(posedge clk); #1;
        chk("held_idle", {48'd0, sum16}, 64'hFFFE);
        idle();
        pin(16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
        op16(16'h8000, 16'h0001, 1'b1);
        wait16(lat);
        idle();
        pin(16'h0000, 16'h8000, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b0);
        op16(16'h0000, 16'h8000, 1'b1);
        wait16(lat);
        idle();
        pin(16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1);
        op16(16'h1234, 16'h0000, 1'b1);
        wait16(lat);
        idle();

        // Test 3: start during RUN is ignored.
        pin(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        op16(16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        wait16(lat);
        chk("lat_t3", lat, 2);
        idle();
        idle();

        // Test 4: asynchronous reset mid-RUN.
        op16(16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("partial_sum", {48'd0, sum16}, 64'h0045);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy16}, 0);
        chk("arst_done", {63'd0, done16}, 0);
        chk("arst_sum", {48'd0, sum16}, 0);
        chk("arst_ovfl", {63'd0, ovfl16}, 0);
        chk("arst_cout", {63'd0, cout16}, 0);
        q16.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        idle();
        pin(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        op16(16'h00FF, 16'h0001, 1'b0);
        wait16(lat);
        chk("lat_t4", lat, 4);
        idle();

        // Test 5: back-to-back, start in the DONE cycle.
        pin(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        op16(16'h1111, 16'h2222, 1'b0);
        wait16(lat);
        chk("held_done", {48'd0, sum16}, 64'h3333);
        op16(16'h4444, 16'h0001, 1'b1);
        chk("done_drop", {63'd0, done16}, 0);
        wait16(lat);
        chk("lat_b2b", lat, 4);
        idle();

        // Test 6: random on all three widths in parallel.
        for (int k = 0; k < 500; k++) begin
            ra = pick(16); rb = pick(16); rs = 1'($urandom);
            a16 = ra[15:0]; b16 = rb[15:0]; sub16 = rs; start16 = 1'b1;
            q16.push_back(model(ra, rb, rs, 16));
            ra = pick(8); rb = pick(8); rs = 1'($urandom);
            a8 = ra[7:0]; b8 = rb[7:0]; sub8 = rs; start8 = 1'b1;
            q8.push_back(model(ra, rb, rs, 8));
            ra = pick(32); rb = pick(32); rs = 1'($urandom);
            a32 = ra; b32 = rb; sub32 = rs; start32 = 1'b1;
            q32.push_back(model(ra, rb, rs, 32));
            @(posedge clk); #1;
            start16 = 1'b0; start8 = 1'b0; start32 = 1'b0;
            cyc = 0;
            while ((q16.size() + q8.size() + q32.size()) != 0 && cyc < 30) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (cyc >= 30) begin
                chk("rand_timeout", 1, 0);
                q16.delete(); q8.delete(); q32.delete();
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
